pipelined_cla_adder: RTL and testbench

Parametrised, two-stage pipelined carry look-ahead adder/subtractor with valid/ready handshaking on both sides. It replaces the fixed 4-bit combinational CLA in datapaths that need wider operands, subtraction, signed-overflow detection and a registered, back-pressurable output. It accepts one operation per cycle at full throughput and sits between an operand source and any consumer that may stall.

---
 rtl/pipelined_cla_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry look-ahead adder/subtractor with valid/ready on both sides.
// S1 registers per-bit and per-group propagate/generate terms; S2 resolves carries and registers the result.

module cla_lookahead #(
   parameter int N = 4
) (
   input  logic [N-1:0] p,
   input  logic [N-1:0] g,
   input  logic         ci,
   output logic [N:0]   c
);
   logic t;

   // Each carry is the flat sum-of-products of generate terms and the carry-in.
   always_comb begin
      c = '0;
      t = 1'b0;
      for (int k = 0; k <= N; k++) begin
         t = ci;
         for (int j = 0; j < k; j++) t = t & p[j];
         c[k] = t;
         for (int j = 0; j < k; j++) begin
            t = g[j];
            for (int m = j + 1; m < k; m++) t = t & p[m];
            c[k] = c[k] | t;
         end
      end
   end
endmodule

module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NG = WIDTH / GROUP;

   logic [WIDTH-1:0] b_eff, p_n, g_n;
   logic             c0;
   logic [NG-1:0]    gp_n, gg_n;

   logic [WIDTH-1:0] p_q, g_q;
   logic             c0_q;
   logic [NG-1:0]    gp_q, gg_q;

   logic [2:1]       vld_pipe;
   logic             adv1, adv2;

   logic [NG:0]             gc;
   logic [NG-1:0][GROUP:0]  lc;
   logic [WIDTH:0]          car;
   logic [NG-1:0]           unused_grp_top;
   logic [WIDTH-1:0]        sum_n;

   assign adv2      = !vld_pipe[2] || out_ready;
   assign adv1      = !vld_pipe[1] || adv2;
   assign in_ready  = adv1;
   assign out_valid = vld_pipe[2];

   assign b_eff = sub ? ~b : b;
   assign c0    = sub | cin;
   assign p_n   = a ^ b_eff;
   assign g_n   = a & b_eff;

   always_comb begin
      gp_n = '0;
      gg_n = '0;
      for (int i = 0; i < NG; i++) begin
         gp_n[i] = &p_n[i*GROUP +: GROUP];
         for (int j = 0; j < GROUP; j++)
            gg_n[i] = g_n[i*GROUP+j] | (p_n[i*GROUP+j] & gg_n[i]);
      end
   end

   cla_lookahead #(.N(NG)) u_grp (.p(gp_q), .g(gg_q), .ci(c0_q), .c(gc));

   // Each group's own carry-out duplicates the next group's look-ahead carry-in.
   for (genvar gi = 0; gi < NG; gi++) begin : g_lane
      cla_lookahead #(.N(GROUP)) u_lane (
         .p (p_q[gi*GROUP +: GROUP]),
         .g (g_q[gi*GROUP +: GROUP]),
         .ci(gc[gi]),
         .c (lc[gi])
      );
      assign car[gi*GROUP +: GROUP] = lc[gi][GROUP-1:0];
      assign unused_grp_top[gi]     = lc[gi][GROUP];
   end
   assign car[WIDTH] = gc[NG];
   assign sum_n      = p_q ^ car[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         p_q      <= '0;
         g_q      <= '0;
         c0_q     <= 1'b0;
         gp_q     <= '0;
         gg_q     <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               sum  <= sum_n;
               cout <= car[WIDTH];
               ovf  <= car[WIDTH-1] ^ car[WIDTH];
            end
         end
         if (adv1) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
               p_q  <= p_n;
               g_q  <= g_n;
               c0_q <= c0;
               gp_q <= gp_n;
               gg_q <= gg_n;
            end
         end
      end
   end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed plus randomized bench for pipelined_cla_adder, scored against an integer-arithmetic model.
module tb_pipelined_cla_adder;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;
   logic        s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
   logic [3:0]  s_a, s_b, s_sum;

   int checks = 0;
   int failures = 0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf));

   pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
      .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .sum(s_sum), .cout(s_cout), .ovf(s_ovf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
   function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
      int sx, sy, sr, ux, uy, ur;
      logic co;
      sx = $signed(x);
      sy = $signed(y);
      ux = x;
      uy = y;
      if (s) begin
         sr = sx - sy;
         ur = ux - uy;
         co = (ux >= uy);
      end else begin
         sr = sx + sy + int'(ci);
         ur = ux + uy + int'(ci);
         co = (ur > 65535);
      end
      return {(sr > 32767 || sr < -32768), co, ur[15:0]};
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // One clock cycle: inputs are already driven; score handshakes just before the edge.
   task automatic cyc();
      logic acc, del;
      logic [17:0] e;
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (rst) begin
         exp_q.delete();
      end else begin
         chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
         if (exp_q.size() == 2) chk("full_out_valid", out_valid, 1);
         if (del) begin
            chk("deliver_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("result", {ovf, cout, sum}, e);
            end
         end
         if (acc) exp_q.push_back(ref_op(a, b, cin, sub));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                       input logic xs, input logic [15:0] es, input logic ec,
                       input logic eo, input string tag);
      int n;
      a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      chk({tag, "_lat1"}, out_valid, 0);
      cyc();
      n = 0;
      while (!out_valid && n < 4) begin cyc(); n++; end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, eo);
      cyc();
   endtask

   task automatic send4(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                        input logic [3:0] es, input logic ec, input string tag);
      s_a = xa; s_b = xb; s_cin = xc; s_sub = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b1;
      chk({tag, "_in_ready"}, s_in_ready, 1);
      @(posedge clk); @(negedge clk);
      s_in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk({tag, "_valid"}, s_out_valid, 1);
      chk({tag, "_sum"}, s_sum, es);
      chk({tag, "_cout"}, s_cout, ec);
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      @(negedge clk);
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);

      send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add");
      send(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, "add_cin");
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_out");
      send(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "sub");
      send(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
      send(16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0, "sub_cin_ignored");

      send4(4'hB, 4'h6, 1'b0, 4'h1, 1'b1, "w4_carry");
      send4(4'h2, 4'h4, 1'b1, 4'h7, 1'b0, "w4_cin");

      // Back-pressure: two beats fill the pipe, the third waits.
      out_ready = 1'b0; b = 16'h0010; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      a = 16'd1; cyc();
      a = 16'd2; cyc();
      a = 16'd3;
      for (int k = 0; k < 2; k++) begin
         chk("bp_in_ready_low", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_sum_held", sum, 16'h0011);
         cyc();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = (k < 2);
         a = 16'(3 + k);
         chk("bp_drain_valid", out_valid, 1);
         chk("bp_drain_sum", sum, 32'h11 + 32'(k));
         cyc();
      end
      chk("bp_empty", out_valid, 0);
      chk("bp_queue", exp_q.size(), 0);

      // Reset with both stages occupied and a beat presented during reset.
      out_ready = 1'b0; in_valid = 1'b1; b = 16'h0000;
      a = 16'h0100; cyc();
      a = 16'h0200; cyc();
      chk("mid_full", out_valid, 1);
      rst = 1'b1; a = 16'h0300; cyc();
      rst = 1'b0; in_valid = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      cyc();
      cyc();
      chk("mid_rst_no_accept", out_valid, 0);
      send(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, "post_rst");

      for (int k = 0; k < 400; k++) begin
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
         cyc();
      end

      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin cyc(); n++; end
      chk("drain", exp_q.size(), 0);
      chk("drain_out_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
